// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave receive front-end.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    END_WAIT,
    COMMIT
  } spi_rx_state_t;

  // Mode 0 and mode 3 sample on the rising edge; modes 1 and 2 sample on the falling edge.
  function automatic logic sample_rising(input int cpol, input int cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage flop synchroniser for one asynchronous input, with a selectable reset level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= RST_VAL ? '1 : '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_rx_frame.sv
// SPI slave receiver: oversampled inputs, one MSB-first DATA_W-bit word per CS frame,
// with length check and CS-high debounce before the word is committed.
module spi_rx_frame
  import spi_pkg::*;
#(
  parameter int DATA_W      = 33,
  parameter int CPOL        = 0,
  parameter int CPHA        = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CS_FILT     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spi_clk,
  input  logic                          spi_cs,
  input  logic                          spi_out,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  output logic                          rx_err,
  output logic                          busy,
  output logic [$clog2(DATA_W+2)-1:0]   bit_cnt
);

  localparam int CW = $clog2(DATA_W + 2);
  localparam int FW = $clog2(CS_FILT + 1);
  localparam logic          SAMPLE_RISE = sample_rising(CPOL, CPHA);
  localparam logic [CW-1:0] CNT_FULL    = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_SAT     = CW'(DATA_W + 1);
  localparam logic [FW-1:0] FILT_END    = FW'(CS_FILT);

  spi_rx_state_t state, state_n;

  logic              sck_s, sck_d, cs_s, spi_out_s;
  logic              sample_edge;
  logic [DATA_W-1:0] shreg;
  logic [FW-1:0]     filt_cnt;

  logic clear, shift_en, filt_ld, filt_inc, commit_good, commit_bad;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_clk (
    .clk(clk), .rst(rst), .d(spi_clk), .q(sck_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs), .q(cs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dat (
    .clk(clk), .rst(rst), .d(spi_out), .q(spi_out_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sck_d <= 1'(CPOL);
    else     sck_d <= sck_s;
  end

  assign sample_edge = SAMPLE_RISE ? (sck_s & ~sck_d) : (~sck_s & sck_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // The commit decision is taken on the END_WAIT->COMMIT transition so the
  // registered strobes line up with the single COMMIT cycle.
  always_comb begin
    state_n     = state;
    clear       = 1'b0;
    shift_en    = 1'b0;
    filt_ld     = 1'b0;
    filt_inc    = 1'b0;
    commit_good = 1'b0;
    commit_bad  = 1'b0;
    case (state)
      IDLE: begin
        clear = 1'b1;
        if (!cs_s) state_n = ACTIVE;
      end
      ACTIVE: begin
        shift_en = sample_edge;
        if (cs_s) begin
          state_n = END_WAIT;
          filt_ld = 1'b1;
        end
      end
      END_WAIT: begin
        if (!cs_s) begin
          state_n = ACTIVE;
        end else if (filt_cnt == FILT_END) begin
          state_n = COMMIT;
          if (bit_cnt == CNT_FULL) commit_good = 1'b1;
          else                     commit_bad  = 1'b1;
        end else begin
          filt_inc = 1'b1;
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[DATA_W-2:0], spi_out_s};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           filt_cnt <= '0;
    else if (filt_ld)  filt_cnt <= FW'(1);
    else if (filt_inc) filt_cnt <= filt_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= commit_good;
      rx_err   <= commit_bad;
      if (commit_good) rx_data <= shreg;
    end
  end

  assign busy = (state == ACTIVE) || (state == END_WAIT);

endmodule
